// File: rtl/float_signed_to_log.sv
// float_signed_to_log
//   Two-stage pipelined converter from the unpacked signed-exponent float
//   format (sign, special flags, two's-complement unbiased exponent,
//   hidden-one fraction) to the unpacked (M, F) log-number format.
//
// Ports:
//   clock, resetn           rising-edge clock, asynchronous active-low reset
//   inValid                 input sample valid
//   in_sign                 input sign
//   in_isInf                input is infinity
//   in_isNan                input is NaN
//   in_isZero               input is zero
//   in_exp   [EXP_IN-1:0]   unbiased two's-complement exponent
//   in_frac  [FRAC_IN-1:0]  fraction, value = (1 + f/2^FRAC_IN) * 2^exp
//   outValid                output valid (inValid delayed by 2 cycles)
//   out_sign                output sign (0 for any special result)
//   out_isInf               infinity / NaR
//   out_isZero              zero
//   out_exp  [M-1:0]        signed integer part of log2|x|
//   out_frac [F-1:0]        unsigned fractional part of log2|x|
module float_signed_to_log #(
    parameter int EXP_IN  = 8,
    parameter int FRAC_IN = 8,
    parameter int M       = 3,
    parameter int F       = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               inValid,
    input  logic               in_sign,
    input  logic               in_isInf,
    input  logic               in_isNan,
    input  logic               in_isZero,
    input  logic [EXP_IN-1:0]  in_exp,
    input  logic [FRAC_IN-1:0] in_frac,
    output logic               outValid,
    output logic               out_sign,
    output logic               out_isInf,
    output logic               out_isZero,
    output logic [M-1:0]       out_exp,
    output logic [F-1:0]       out_frac
);

    localparam int unsigned DEPTH = 1 << FRAC_IN;
    localparam int unsigned ROM_W = DEPTH * (F + 1);
    // Wide enough to hold in_exp + 1 and to compare against the M-bit range
    localparam int          W     = ((EXP_IN > M) ? EXP_IN : M) + 2;
    // Fixed-point fraction bits used while building the ROM
    localparam int          FXP   = 60;

    // round(log2(1 + f/2^FRAC_IN) * 2^F), ties up.
    // Bit-serial log2 by repeated squaring: each squaring of y in [1,2)
    // yields the next fraction bit. F+1 bits are produced, then rounded.
    function automatic logic [F:0] rom_entry(input int unsigned f);
        logic [127:0] y;
        logic [F+1:0] bits;
        logic [F+1:0] rnd;
        y    = 128'(f) + (128'(1) << FRAC_IN);
        y    = y << (FXP - FRAC_IN);
        bits = '0;
        for (int unsigned i = 0; i < unsigned'(F + 1); i++) begin
            y    = (y * y) >> FXP;
            bits = bits << 1;
            if (y[FXP+1]) begin
                bits[0] = 1'b1;
                y       = y >> 1;
            end
        end
        rnd = (bits + 1'b1) >> 1;
        return rnd[F:0];
    endfunction

    function automatic logic [ROM_W-1:0] build_rom();
        logic [ROM_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            v[i*(F+1) +: (F+1)] = rom_entry(i);
        end
        return v;
    endfunction

    localparam logic [ROM_W-1:0] ROM_BITS = build_rom();

    localparam logic signed [W-1:0] E_MAX = W'((1 << (M - 1)) - 1);
    localparam logic signed [W-1:0] E_MIN = -E_MAX - W'(1);

    // ---------------- stage 1: ROM lookup, exponent and flags ----------------
    logic              v1_d,    v1_q;
    logic              sign1_d, sign1_q;
    logic              inf1_d,  inf1_q;
    logic              zero1_d, zero1_q;
    logic [EXP_IN-1:0] exp1_d,  exp1_q;
    logic [F:0]        rom1_d,  rom1_q;

    always_comb begin
        v1_d    = inValid;
        sign1_d = in_sign;
        inf1_d  = in_isInf | in_isNan;
        zero1_d = in_isZero;
        exp1_d  = in_exp;
        rom1_d  = ROM_BITS[int'(in_frac) * (F + 1) +: (F + 1)];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            exp1_q  <= '0;
            rom1_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            sign1_q <= sign1_d;
            inf1_q  <= inf1_d;
            zero1_q <= zero1_d;
            exp1_q  <= exp1_d;
            rom1_q  <= rom1_d;
        end
    end

    // ---------------- stage 2: carry, range check, specials ------------------
    logic              v2_d,    v2_q;
    logic              sign2_d, sign2_q;
    logic              inf2_d,  inf2_q;
    logic              zero2_d, zero2_q;
    logic [M-1:0]      exp2_d,  exp2_q;
    logic [F-1:0]      frac2_d, frac2_q;
    logic signed [W-1:0] e_ext;

    always_comb begin
        // A ROM value of exactly 2^F has zero low bits, so the fraction is
        // already 0 on carry; only the exponent needs the +1.
        e_ext   = $signed({{(W - EXP_IN){exp1_q[EXP_IN-1]}}, exp1_q})
                  + $signed(W'(rom1_q[F]));
        v2_d    = v1_q;
        sign2_d = 1'b0;
        inf2_d  = 1'b0;
        zero2_d = 1'b0;
        exp2_d  = '0;
        frac2_d = '0;
        if (inf1_q) begin
            inf2_d = 1'b1;
        end else if (zero1_q) begin
            zero2_d = 1'b1;
        end else if (e_ext > E_MAX) begin
            inf2_d = 1'b1;
        end else if (e_ext < E_MIN) begin
            zero2_d = 1'b1;
        end else begin
            sign2_d = sign1_q;
            exp2_d  = e_ext[M-1:0];
            frac2_d = rom1_q[F-1:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            inf2_q  <= 1'b0;
            zero2_q <= 1'b0;
            exp2_q  <= '0;
            frac2_q <= '0;
        end else begin
            v2_q    <= v2_d;
            sign2_q <= sign2_d;
            inf2_q  <= inf2_d;
            zero2_q <= zero2_d;
            exp2_q  <= exp2_d;
            frac2_q <= frac2_d;
        end
    end

    assign outValid   = v2_q;
    assign out_sign   = sign2_q;
    assign out_isInf  = inf2_q;
    assign out_isZero = zero2_q;
    assign out_exp    = exp2_q;
    assign out_frac   = frac2_q;

endmodule

// File: tb/tb_float_signed_to_log.sv
// Directed self-checking bench for float_signed_to_log (default parameters).
// Output vector compared as {valid, sign, isInf, isZero, exp[2:0], frac[3:0]}.
module tb_float_signed_to_log;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       inValid = 1'b0;
    logic       in_sign = 1'b0;
    logic       in_isInf = 1'b0;
    logic       in_isNan = 1'b0;
    logic       in_isZero = 1'b0;
    logic [7:0] in_exp = '0;
    logic [7:0] in_frac = '0;
    logic       outValid;
    logic       out_sign;
    logic       out_isInf;
    logic       out_isZero;
    logic [2:0] out_exp;
    logic [3:0] out_frac;

    int passed = 0;
    int total  = 0;

    float_signed_to_log #(.EXP_IN(8), .FRAC_IN(8), .M(3), .F(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .inValid    (inValid),
        .in_sign    (in_sign),
        .in_isInf   (in_isInf),
        .in_isNan   (in_isNan),
        .in_isZero  (in_isZero),
        .in_exp     (in_exp),
        .in_frac    (in_frac),
        .outValid   (outValid),
        .out_sign   (out_sign),
        .out_isInf  (out_isInf),
        .out_isZero (out_isZero),
        .out_exp    (out_exp),
        .out_frac   (out_frac)
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] obs();
        return {outValid, out_sign, out_isInf, out_isZero, out_exp, out_frac};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp_v);
        logic [10:0] o;
        o = obs();
        total++;
        assert (o === exp_v) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, o, exp_v);
    endtask

    task automatic check_valid(input string tag, input logic exp_v);
        total++;
        assert (outValid === exp_v) passed++;
        else $error("FAIL %s: observed outValid %b expected %b", tag, outValid, exp_v);
    endtask

    task automatic drive(input logic s, input logic inf, input logic nan,
                         input logic z, input logic [7:0] e, input logic [7:0] f);
        inValid   = 1'b1;
        in_sign   = s;
        in_isInf  = inf;
        in_isNan  = nan;
        in_isZero = z;
        in_exp    = e;
        in_frac   = f;
    endtask

    // One isolated sample: drive, drop valid, check two edges later.
    task automatic apply(input string tag, input logic s, input logic inf,
                         input logic nan, input logic z, input logic [7:0] e,
                         input logic [7:0] f, input logic [10:0] exp_v);
        @(negedge clock);
        drive(s, inf, nan, z, e, f);
        @(negedge clock);
        inValid = 1'b0;
        @(negedge clock);
        check(tag, exp_v);
    endtask

    // Reference for the streaming section: real-valued log2 rounded to 4 bits
    function automatic logic [10:0] ref_log(input int fr);
        real r;
        int  l;
        r = $ln(1.0 + fr / 256.0) / $ln(2.0) * 16.0;
        l = int'($floor(r + 0.5));
        if (l >= 16) return {4'b1000, 3'd1, 4'd0};
        return {4'b1000, 3'd0, 4'(l)};
    endfunction

    initial begin
        logic [10:0] exp_q[$];
        // reset state
        #2;
        check("reset_state", 11'b0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // {v,s,inf,z} exp frac
        apply("one",        0,0,0,0, 8'd0,   8'h00, {4'b1000, 3'd0, 4'b0000});
        apply("two",        0,0,0,0, 8'd1,   8'h00, {4'b1000, 3'd1, 4'b0000});
        apply("one_half",   0,0,0,0, 8'd0,   8'h80, {4'b1000, 3'd0, 4'b1001});
        apply("frac_f3",    0,0,0,0, 8'd0,   8'hF3, {4'b1000, 3'd0, 4'b1111});
        apply("carry_ff",   0,0,0,0, 8'd0,   8'hFF, {4'b1000, 3'd1, 4'b0000});
        apply("carry_neg1", 0,0,0,0, 8'hFF,  8'hFF, {4'b1000, 3'd0, 4'b0000});
        apply("exp_max",    0,0,0,0, 8'd3,   8'h00, {4'b1000, 3'd3, 4'b0000});
        apply("carry_ovf",  0,0,0,0, 8'd3,   8'hFF, {4'b1010, 3'd0, 4'b0000});
        apply("exp_ovf",    0,0,0,0, 8'd4,   8'h40, {4'b1010, 3'd0, 4'b0000});
        apply("exp_127",    1,0,0,0, 8'd127, 8'h00, {4'b1010, 3'd0, 4'b0000});
        apply("exp_min",    0,0,0,0, 8'hFC,  8'h00, {4'b1000, 3'b100, 4'b0000});
        apply("exp_unf",    1,0,0,0, 8'hFB,  8'h80, {4'b1001, 3'd0, 4'b0000});
        apply("exp_m128",   0,0,0,0, 8'h80,  8'h00, {4'b1001, 3'd0, 4'b0000});
        apply("nan",        0,0,1,0, 8'd0,   8'h80, {4'b1010, 3'd0, 4'b0000});
        apply("inf_neg",    1,1,0,0, 8'd1,   8'h10, {4'b1010, 3'd0, 4'b0000});
        apply("zero",       0,0,0,1, 8'd2,   8'h80, {4'b1001, 3'd0, 4'b0000});
        apply("nan_zero",   1,0,1,1, 8'd0,   8'h00, {4'b1010, 3'd0, 4'b0000});
        apply("neg_1p5",    1,0,0,0, 8'd0,   8'h80, {4'b1100, 3'd0, 4'b1001});

        // Streaming: 20 back-to-back samples 1.0 + i/20
        for (int c = 0; c < 22; c++) begin
            @(negedge clock);
            if (c >= 2) check($sformatf("stream_%0d", c - 2), exp_q.pop_front());
            else        check_valid($sformatf("stream_idle_%0d", c), 1'b0);
            if (c < 20) begin
                drive(0, 0, 0, 0, 8'd0, 8'((c * 256) / 20));
                exp_q.push_back(ref_log((c * 256) / 20));
            end else begin
                inValid = 1'b0;
            end
        end

        // Reset mid-stream
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            drive(0, 0, 0, 0, 8'd1, 8'h80);
        end
        check("pre_reset_valid", {4'b1000, 3'd1, 4'b1001});
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", 11'b0);
        @(negedge clock);
        inValid = 1'b0;
        resetn  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check_valid($sformatf("post_reset_idle_%0d", c), 1'b0);
        end
        drive(0, 0, 0, 0, 8'd0, 8'h80);
        @(negedge clock);
        inValid = 1'b0;
        check_valid("post_reset_lat1", 1'b0);
        @(negedge clock);
        check("post_reset_lat2", {4'b1000, 3'd0, 4'b1001});
        @(negedge clock);
        check_valid("post_reset_drop", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
